johnson_decoder: RTL
====================

JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
- REQ-001 SHALL have parameter LOCK_CNT, default 3: consecutive legal single-step advances required to enter LOCKED (legal range 1..15).
- REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
- REQ-004 SHALL have port jc_in, input, 5: sampled 5-bit twisted-ring (Johnson) code.
- REQ-005 SHALL have port jc_valid, input, 1: jc_in is sampled on an edge where jc_valid=1; otherwise all state holds.
- REQ-006 SHALL have port clear_err, input, 1: synchronous clear of err_sticky.
- REQ-007 SHALL have port index, output, 4: decoded position 0..9, or 4'hF for an illegal code.
- REQ-008 SHALL have port onehot, output, 10: onehot[index] for a legal code; all zero otherwise.
- REQ-009 SHALL have port legal, output, 1: last sample was one of the 10 legal codes.
- REQ-010 SHALL have port step_err, output, 1: one-cycle pulse flagging an illegal code or an illegal step.
- REQ-011 SHALL have port err_sticky, output, 1: set by any step_err; held until clear_err.
- REQ-012 SHALL have port wrap_count, output, 8: count of 9->0 wraps, saturating at 255.
- REQ-013 SHALL have port locked, output, 1: FSM is in LOCKED.

Function
- REQ-014 SHALL decode the legal codes to index as follows: 00000=0, 00001=1, 00011=2, 00111=3, 01111=4, 11111=5, 11110=6, 11100=7, 11000=8, 10000=9.
- REQ-015 SHALL treat the other 22 codes as illegal.
- REQ-016 SHALL register all outputs; a sample on edge N SHALL be visible after edge N, giving 1-cycle latency.
- REQ-017 SHALL drive step_err high only for the cycle following the offending sample; it SHALL be 0 whenever jc_valid=0 on the prior edge.
- REQ-018 SHALL use an FSM with states UNLOCKED (no previous sample), TRACKING (previous legal sample stored, good_cnt<LOCK_CNT) and LOCKED.
- REQ-019 SHALL classify each step against the stored previous index p: "hold" if new index = p; "advance" if new index = (p+1) mod 10; "bad" otherwise.
- REQ-020 SHALL, on a legal sample in UNLOCKED, store the index, set good_cnt=0, go to TRACKING, and assert no step_err.
- REQ-021 SHALL, on an advance in TRACKING, increment good_cnt and go to LOCKED when good_cnt reaches LOCK_CNT.
- REQ-022 SHALL, on an advance in LOCKED, stay in LOCKED.
- REQ-023 SHALL, on a hold in TRACKING or LOCKED, leave state and good_cnt unchanged; a hold is not an error.
- REQ-024 SHALL, on a bad step in TRACKING or LOCKED, pulse step_err, go to TRACKING with good_cnt=0, and store the new index.
- REQ-025 SHALL, on an illegal code in any state, drive index=4'hF, onehot=0, legal=0; go to UNLOCKED and discard the previous index.
- REQ-026 SHALL pulse step_err for an illegal code except when the FSM is already in UNLOCKED.
- REQ-027 SHALL increment wrap_count (saturating at 255) on every advance from 9 to 0, in TRACKING or LOCKED.
- REQ-028 SHALL give a new error priority when clear_err and a new error occur on the same edge, leaving err_sticky=1.
- REQ-029 SHALL leave wrap_count, the FSM and index unaffected by clear_err.

Reset
- REQ-030 SHALL, while reset_n=0, immediately force: index=0, onehot=0, legal=0, step_err=0, err_sticky=0, wrap_count=0, locked=0, good_cnt=0, FSM=UNLOCKED.
- REQ-031 SHALL, when reset asserts mid-operation, lose all history; the first legal sample after release behaves as in REQ-020.

Verification
- REQ-032 SHALL cover: release reset, jc_valid=1, feed 00000,00001,00011,00111 -> index 0,1,2,3 one cycle late; locked=1 after the 4th sample; step_err never set.
- REQ-033 SHALL cover: 22 full cycles of the legal sequence (LOCK_CNT=3) -> wrap_count=22; then 300 further wraps -> wrap_count=255.
- REQ-034 SHALL cover: while locked at index 2 (00011), inject 01111 -> step_err pulse, err_sticky=1, locked=0, index=4; then 11111 -> no error, state TRACKING.
- REQ-035 SHALL cover: inject 00101 -> index=F, onehot=0, legal=0, step_err pulse, FSM UNLOCKED; then 11000 -> index=8, no step_err.
- REQ-036 SHALL cover: assert clear_err on the same edge as a bad step -> err_sticky remains 1; clear_err alone on the next edge -> err_sticky=0.
- REQ-037 SHALL cover: repeat 00111 with jc_valid toggling, then drop reset_n mid-cycle -> holds produce no errors; all outputs go to reset values before the next clk edge.

Source files
------------

// File: rtl/johnson_decoder.sv
// Decodes a 5-bit twisted-ring code to a position and checks that consecutive
// samples move forward one step at a time. Tracks lock state, errors and 9->0 wraps.
module johnson_decoder #(
    parameter int LOCK_CNT = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] jc_in,
    input  logic       jc_valid,
    input  logic       clear_err,
    output logic [3:0] index,
    output logic [9:0] onehot,
    output logic       legal,
    output logic       step_err,
    output logic       err_sticky,
    output logic [7:0] wrap_count,
    output logic       locked
);

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_TRACKING = 2'd1,
        S_LOCKED   = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_W = 4'(LOCK_CNT);

    state_t     state_q, state_d;
    logic [3:0] good_cnt_q, good_cnt_d;
    logic [3:0] index_q, index_d;
    logic [9:0] onehot_q, onehot_d;
    logic       legal_q, legal_d;
    logic       step_err_q, step_err_d;
    logic       err_q, err_d;
    logic [7:0] wrap_q, wrap_d;

    logic [3:0] dec_idx;
    logic       dec_legal;
    logic [9:0] dec_onehot;
    logic [3:0] next_idx;
    logic       is_hold, is_adv, have_prev;

    always_comb begin
        dec_legal = 1'b1;
        dec_idx   = 4'd0;
        case (jc_in)
            5'b00000: dec_idx = 4'd0;
            5'b00001: dec_idx = 4'd1;
            5'b00011: dec_idx = 4'd2;
            5'b00111: dec_idx = 4'd3;
            5'b01111: dec_idx = 4'd4;
            5'b11111: dec_idx = 4'd5;
            5'b11110: dec_idx = 4'd6;
            5'b11100: dec_idx = 4'd7;
            5'b11000: dec_idx = 4'd8;
            5'b10000: dec_idx = 4'd9;
            default: begin
                dec_legal = 1'b0;
                dec_idx   = 4'hF;
            end
        endcase
    end

    for (genvar gi = 0; gi < 10; gi++) begin : g_onehot
        assign dec_onehot[gi] = dec_legal && (dec_idx == 4'(gi));
    end

    // index_q doubles as the stored previous position whenever we are not UNLOCKED
    assign next_idx  = (index_q == 4'd9) ? 4'd0 : index_q + 4'd1;
    assign is_hold   = (dec_idx == index_q);
    assign is_adv    = (dec_idx == next_idx);
    assign have_prev = (state_q != S_UNLOCKED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_UNLOCKED;
            good_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        if (jc_valid) begin
            if (!dec_legal) begin
                state_d    = S_UNLOCKED;
                good_cnt_d = 4'd0;
            end else begin
                case (state_q)
                    S_UNLOCKED: begin
                        state_d    = S_TRACKING;
                        good_cnt_d = 4'd0;
                    end
                    S_TRACKING: begin
                        if (is_adv) begin
                            good_cnt_d = good_cnt_q + 4'd1;
                            if (good_cnt_d == LOCK_W) state_d = S_LOCKED;
                        end else if (!is_hold) begin
                            good_cnt_d = 4'd0;
                        end
                    end
                    S_LOCKED: begin
                        if (!is_adv && !is_hold) begin
                            state_d    = S_TRACKING;
                            good_cnt_d = 4'd0;
                        end
                    end
                    default: begin
                        state_d    = S_UNLOCKED;
                        good_cnt_d = 4'd0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        index_d    = index_q;
        onehot_d   = onehot_q;
        legal_d    = legal_q;
        step_err_d = 1'b0;
        err_d      = err_q;
        wrap_d     = wrap_q;
        if (clear_err) err_d = 1'b0;
        if (jc_valid) begin
            index_d  = dec_idx;
            onehot_d = dec_onehot;
            legal_d  = dec_legal;
            if (!dec_legal)
                step_err_d = have_prev;
            else if (have_prev && !is_hold && !is_adv)
                step_err_d = 1'b1;
            if (dec_legal && have_prev && is_adv && (index_q == 4'd9) && (wrap_q != 8'hFF))
                wrap_d = wrap_q + 8'd1;
        end
        // a fresh error outranks a simultaneous clear
        if (step_err_d) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index_q    <= 4'd0;
            onehot_q   <= 10'd0;
            legal_q    <= 1'b0;
            step_err_q <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 8'd0;
        end else begin
            index_q    <= index_d;
            onehot_q   <= onehot_d;
            legal_q    <= legal_d;
            step_err_q <= step_err_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
        end
    end

    assign index      = index_q;
    assign onehot     = onehot_q;
    assign legal      = legal_q;
    assign step_err   = step_err_q;
    assign err_sticky = err_q;
    assign wrap_count = wrap_q;
    assign locked     = (state_q == S_LOCKED);

endmodule
